tcb_lib_register_response: RTL and testbench



---
 rtl/tcb_pkg.sv | 36 +++
 rtl/tcb_lib_rsp_track.sv | 80 ++++++++
 rtl/tcb_lib_register_response.sv | 118 +++++++++++
 tb/tb_tcb_lib_register_response.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/tcb_pkg.sv
// -----------------------------------------------------------------------------
// tcb_pkg
// Shared helpers for the tcb_lib_* register slices.
//   tcb_cnt_w    : width of an outstanding-transfer counter for a given delay
//                  (the count can reach DLY+1, plus headroom for DLY+2).
//   tcb_ben_mask : zero every byte lane of a read data word whose byte enable
//                  is low. Works on the widest supported bus; callers
//                  zero-extend their operands and truncate the result.
// -----------------------------------------------------------------------------
package tcb_pkg;

    localparam int unsigned TCB_MAX_DBW = 256;
    localparam int unsigned TCB_MAX_BEW = 32;

    function automatic int unsigned tcb_cnt_w(input int unsigned dly);
        return $clog2(dly + 3);
    endfunction

    function automatic logic [TCB_MAX_DBW-1:0] tcb_ben_mask(
        input logic [TCB_MAX_DBW-1:0] rdt,
        input logic [TCB_MAX_BEW-1:0] ben,
        input int unsigned            slw
    );
        logic [TCB_MAX_DBW-1:0]         m;
        logic [$clog2(TCB_MAX_DBW)-1:0] bit_i;
        logic [$clog2(TCB_MAX_BEW)-1:0] lane_i;
        m = '0;
        for (int unsigned i = 0; i < TCB_MAX_DBW; i++) begin
            bit_i  = ($clog2(TCB_MAX_DBW))'(i);
            lane_i = ($clog2(TCB_MAX_BEW))'(i / slw);
            if (ben[lane_i]) m[bit_i] = rdt[bit_i];
        end
        return m;
    endfunction

endpackage

// File: rtl/tcb_lib_rsp_track.sv
// -----------------------------------------------------------------------------
// tcb_lib_rsp_track
// Tracks transfers through a response pipeline of depth DLY and counts the
// transfers that have not yet been answered on the upstream side (DLY+1).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_trn      upstream transfer (vld & rdy) this cycle
//   i_wen      write enable of the transfer
//   i_ben      byte enables of the transfer
//   o_rsp_d    downstream response cycle (DLY cycles after the transfer)
//   o_wen_d    write enable belonging to o_rsp_d
//   o_ben_d    byte enables belonging to o_rsp_d
//   o_cnt      number of outstanding transfers
// -----------------------------------------------------------------------------
module tcb_lib_rsp_track
    import tcb_pkg::*;
#(
    parameter int unsigned BEW  = 4,
    parameter int unsigned DLY  = 1,
    parameter int unsigned CNTW = tcb_cnt_w(DLY)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_trn,
    input  logic            i_wen,
    input  logic [BEW-1:0]  i_ben,
    output logic            o_rsp_d,
    output logic            o_wen_d,
    output logic [BEW-1:0]  o_ben_d,
    output logic [CNTW-1:0] o_cnt
);

    logic [DLY:0]    r_trn;
    logic [CNTW-1:0] r_cnt;
    logic            w_rsp_u;

    // Shift in from the bottom; the truncating cast drops the oldest stage.
    always_ff @(posedge clk) begin
        if (rst) r_trn <= '0;
        else     r_trn <= (DLY+1)'({r_trn, i_trn});
    end

    // Upstream response is one stage past the downstream one.
    assign w_rsp_u = r_trn[DLY];

    // wen/ben are only needed up to the downstream response stage, so their
    // pipes stop one stage short of the trn pipe.
    generate
        if (DLY == 0) begin : g_dly0
            assign o_rsp_d = i_trn;
            assign o_wen_d = i_wen;
            assign o_ben_d = i_ben;
        end else begin : g_dlyn
            logic [DLY-1:0]          r_wen;
            logic [DLY-1:0][BEW-1:0] r_ben;
            always_ff @(posedge clk) begin
                r_wen <= DLY'({r_wen, i_wen});
                r_ben <= (DLY*BEW)'({r_ben, i_ben});
            end
            assign o_rsp_d = r_trn[DLY-1];
            assign o_wen_d = r_wen[DLY-1];
            assign o_ben_d = r_ben[DLY-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({i_trn, w_rsp_u})
                2'b10:   r_cnt <= r_cnt + CNTW'(1);
                2'b01:   r_cnt <= r_cnt - CNTW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/tcb_lib_register_response.sv
// -----------------------------------------------------------------------------
// tcb_lib_register_response
// Register slice on the TCB response path. Requests and handshake pass
// straight through; read data and error are registered, so the upstream side
// sees a response delay of DLY+1 while the downstream side runs at DLY.
// Read data lanes are zeroed where ben is low, and writes return zero data.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_sub_* / o_sub_*  upstream (manager-facing) TCB, delay DLY+1
//   o_man_* / i_man_*  downstream (subordinate-facing) TCB, delay DLY
//   o_idl           high when no transfer is outstanding
// Build option: TCB_LIB_RSP_HOLD_EN -- when defined, rdt/err load only in
// downstream response cycles and hold in between; otherwise they load every
// cycle and read zero outside response cycles.
// -----------------------------------------------------------------------------
module tcb_lib_register_response
    import tcb_pkg::*;
#(
    parameter int unsigned ABW = 32,
    parameter int unsigned DBW = 32,
    parameter int unsigned SLW = 8,
    parameter int unsigned DLY = 1
) (
    input  logic               clk,
    input  logic               rst,
    // upstream side
    input  logic               i_sub_vld,
    output logic               o_sub_rdy,
    input  logic               i_sub_rpt,
    input  logic               i_sub_lck,
    input  logic               i_sub_wen,
    input  logic [ABW-1:0]     i_sub_adr,
    input  logic [DBW/SLW-1:0] i_sub_ben,
    input  logic [DBW-1:0]     i_sub_wdt,
    output logic [DBW-1:0]     o_sub_rdt,
    output logic               o_sub_err,
    // downstream side
    output logic               o_man_vld,
    input  logic               i_man_rdy,
    output logic               o_man_rpt,
    output logic               o_man_lck,
    output logic               o_man_wen,
    output logic [ABW-1:0]     o_man_adr,
    output logic [DBW/SLW-1:0] o_man_ben,
    output logic [DBW-1:0]     o_man_wdt,
    input  logic [DBW-1:0]     i_man_rdt,
    input  logic               i_man_err,
    // status
    output logic               o_idl
);

    localparam int unsigned BEW  = DBW / SLW;
    localparam int unsigned CNTW = tcb_cnt_w(DLY);

    logic            w_trn;
    logic            w_rsp_d;
    logic            w_wen_d;
    logic [BEW-1:0]  w_ben_d;
    logic [CNTW-1:0] w_cnt;
    logic [DBW-1:0]  w_rdt_rsp;
    logic [DBW-1:0]  r_rdt;
    logic            r_err;

    // Request path: combinational, gated off while in reset.
    assign o_man_vld = i_sub_vld & ~rst;
    assign o_sub_rdy = i_man_rdy & ~rst;
    assign o_man_rpt = i_sub_rpt;
    assign o_man_lck = i_sub_lck;
    assign o_man_wen = i_sub_wen;
    assign o_man_adr = i_sub_adr;
    assign o_man_ben = i_sub_ben;
    assign o_man_wdt = i_sub_wdt;

    assign w_trn = i_sub_vld & o_sub_rdy;

    tcb_lib_rsp_track #(
        .BEW  (BEW),
        .DLY  (DLY),
        .CNTW (CNTW)
    ) u_trk (
        .clk     (clk),
        .rst     (rst),
        .i_trn   (w_trn),
        .i_wen   (i_sub_wen),
        .i_ben   (i_sub_ben),
        .o_rsp_d (w_rsp_d),
        .o_wen_d (w_wen_d),
        .o_ben_d (w_ben_d),
        .o_cnt   (w_cnt)
    );

    assign w_rdt_rsp = w_wen_d ? '0
                     : DBW'(tcb_ben_mask(TCB_MAX_DBW'(i_man_rdt),
                                         TCB_MAX_BEW'(w_ben_d), SLW));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdt <= '0;
            r_err <= 1'b0;
        end
`ifdef TCB_LIB_RSP_HOLD_EN
        else if (w_rsp_d) begin
            r_rdt <= w_rdt_rsp;
            r_err <= i_man_err;
        end
`else
        else begin
            r_rdt <= w_rsp_d ? w_rdt_rsp : '0;
            r_err <= w_rsp_d & i_man_err;
        end
`endif
    end

    assign o_sub_rdt = r_rdt;
    assign o_sub_err = r_err;
    assign o_idl     = (w_cnt == '0);

endmodule

// File: tb/tb_tcb_lib_register_response.sv
// -----------------------------------------------------------------------------
// tb_tcb_lib_register_response
// Directed bench for the response register slice at DLY=1, DBW=32. Each step
// drives one cycle of stimulus; expected upstream responses go into a
// scoreboard queue when the transfer is driven and are compared when due.
// -----------------------------------------------------------------------------
module tb_tcb_lib_register_response;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_sub_vld = 1'b0, i_sub_rpt = 1'b0, i_sub_lck = 1'b0, i_sub_wen = 1'b0;
    logic [31:0] i_sub_adr = '0, i_sub_wdt = '0;
    logic [3:0]  i_sub_ben = '0;
    logic        i_man_rdy = 1'b0, i_man_err = 1'b0;
    logic [31:0] i_man_rdt = '0;
    logic        o_sub_rdy, o_sub_err, o_man_vld, o_man_rpt, o_man_lck, o_man_wen, o_idl;
    logic [31:0] o_sub_rdt, o_man_adr, o_man_wdt;
    logic [3:0]  o_man_ben;

    always #5 clk = ~clk;

    tcb_lib_register_response #(.ABW(32), .DBW(32), .SLW(8), .DLY(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_sub_vld (i_sub_vld),
        .o_sub_rdy (o_sub_rdy),
        .i_sub_rpt (i_sub_rpt),
        .i_sub_lck (i_sub_lck),
        .i_sub_wen (i_sub_wen),
        .i_sub_adr (i_sub_adr),
        .i_sub_ben (i_sub_ben),
        .i_sub_wdt (i_sub_wdt),
        .o_sub_rdt (o_sub_rdt),
        .o_sub_err (o_sub_err),
        .o_man_vld (o_man_vld),
        .i_man_rdy (i_man_rdy),
        .o_man_rpt (o_man_rpt),
        .o_man_lck (o_man_lck),
        .o_man_wen (o_man_wen),
        .o_man_adr (o_man_adr),
        .o_man_ben (o_man_ben),
        .o_man_wdt (o_man_wdt),
        .i_man_rdt (i_man_rdt),
        .i_man_err (i_man_err),
        .o_idl     (o_idl)
    );

    typedef struct {
        int          due;
        logic [31:0] rdt;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];   // upstream responses still owed by the DUT
    rsp_t sub_q[$];   // data the subordinate model must present downstream
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;
    bit   after_rst = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
            $error("check %s did not match", tag);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [31:0] r, input logic [3:0] b);
        return {b[3] ? r[31:24] : 8'h00, b[2] ? r[23:16] : 8'h00,
                b[1] ? r[15:8]  : 8'h00, b[0] ? r[7:0]   : 8'h00};
    endfunction

    // One clock cycle: r=rst, v=vld, w=wen, a=adr, b=ben, d=wdt, rd=downstream
    // rdy, srdt/serr = what the subordinate answers one cycle later.
    task automatic step(input logic r, input logic v, input logic w,
                        input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                        input logic rd, input logic [31:0] srdt, input logic serr);
        int   cnt_exp;
        rsp_t e;
        bit   quiet;
        @(negedge clk);
        cyc++;
        cnt_exp = exp_q.size();
        if (sub_q.size() != 0 && sub_q[0].due == cyc) begin
            e = sub_q.pop_front();
            i_man_rdt = e.rdt;
            i_man_err = e.err;
        end else begin
            // outside response cycles the subordinate drives junk
            i_man_rdt = $urandom;
            i_man_err = 1'($urandom);
        end
        rst = r;
        i_sub_vld = v; i_sub_wen = w; i_sub_adr = a; i_sub_ben = b; i_sub_wdt = d;
        i_sub_rpt = a[4]; i_sub_lck = a[5]; i_man_rdy = rd;
        #1;
        chk("req", 128'({o_man_vld, o_sub_rdy, o_man_rpt, o_man_lck, o_man_wen,
                         o_man_adr, o_man_ben, o_man_wdt}),
                   128'({v & ~r, rd & ~r, a[4], a[5], w, a, b, d}));
        if (!r) begin
            chk("cnt", 128'(dut.w_cnt), 128'(cnt_exp));
            chk("idl", 128'(o_idl), 128'(cnt_exp == 0));
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("rsp", 128'({o_sub_err, o_sub_rdt}), 128'({e.err, e.rdt}));
            end else begin
                quiet = after_rst;
`ifndef TCB_LIB_RSP_HOLD_EN
                quiet = 1'b1;
`endif
                if (quiet) chk("quiet", 128'({o_sub_err, o_sub_rdt}), 128'(0));
            end
        end
        after_rst = r;
        if (r) begin
            exp_q.delete();
            sub_q.delete();
        end else if (v && rd) begin
            exp_q.push_back('{cyc + 2, w ? 32'h0 : bmask(srdt, b), serr});
            sub_q.push_back('{cyc + 1, srdt, serr});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] b, input logic [31:0] srdt, input logic serr);
        step(1'b0, 1'b1, 1'b0, a, b, 32'h0, 1'b1, srdt, serr);
    endtask

    initial begin
        // reset with a request presented: handshake must stay gated
        step(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h20, 4'hF, 32'h1, 1'b1, 32'h0, 1'b0);
        idle(2);

        // single full-width read
        rd(32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        idle(3);

        // partial-lane read, then a write
        rd(32'h14, 4'b0101, 32'hAABB_CCDD, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 1'b1, 32'h18, 4'hF, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b0);
        idle(3);

        // back-to-back reads
        for (int i = 0; i < 8; i++) rd(32'h100 + 32'(i * 4), 4'hF, 32'(i), 1'b0);
        idle(3);

        // downstream stall: no transfer, no response
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
        idle(2);

        // error on the middle of three reads
        rd(32'h50, 4'hF, 32'h1111_1111, 1'b0);
        rd(32'h54, 4'hF, 32'h2222_2222, 1'b1);
        rd(32'h58, 4'hF, 32'h3333_3333, 1'b0);
        idle(3);

        // write carrying an error
        step(1'b0, 1'b1, 1'b1, 32'h60, 4'h3, 32'hCAFE_F00D, 1'b1, 32'h5555_5555, 1'b1);
        idle(3);

        // reset with two reads in flight
        rd(32'h70, 4'hF, 32'h7777_7777, 1'b1);
        rd(32'h74, 4'hF, 32'h8888_8888, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
        idle(3);

        // mixed traffic
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom,
                 1'($urandom), $urandom, 1'($urandom));
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
